// File: rtl/clock_ctrl_pkg.sv
// Shared types for the clock time-set controller: FSM states and adj_sel encodings.
package clock_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        REPEAT,
        RELEASE
    } state_e;

    localparam logic SEL_MIN  = 1'b0;
    localparam logic SEL_HOUR = 1'b1;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for one raw asynchronous button input.
module btn_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/clock_adjust_ctrl.sv
// Time-set controller: debounced minute/hour adjust strobes and seconds-tick arbitration.
// Define AUTO_REPEAT_EN to enable auto-repeat stepping while a button is held.
module clock_adjust_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int DB_CYCLES   = 2_000_000,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int RATE_CYCLES = 10_000_000
) (
    input  logic CP_100MHz,
    input  logic nCLR,
    input  logic EN,
    input  logic tick_1hz,
    input  logic Adj_Minute,
    input  logic Adj_Hour,
    output logic sec_inc,
    output logic min_inc,
    output logic hour_inc,
    output logic adj_active,
    output logic adj_sel
);

    localparam int MAX_DH  = (DB_CYCLES > HOLD_CYCLES) ? DB_CYCLES : HOLD_CYCLES;
    localparam int MAX_CYC = (MAX_DH > RATE_CYCLES) ? MAX_DH : RATE_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] DB_LOAD   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RATE_LOAD = CNT_W'(RATE_CYCLES - 1);
`endif

    logic             min_s, hour_s, owner_lvl, step;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             owner_q, owner_d;
    logic             adj_sel_q, adj_sel_d;
    logic             min_inc_q, hour_inc_q, sec_inc_q, adj_active_q;
    logic             min_inc_d, hour_inc_d, sec_inc_d, adj_active_d;

    btn_sync u_sync_min (
        .clk_i  (CP_100MHz),
        .rst_ni (nCLR),
        .d_i    (Adj_Minute),
        .q_o    (min_s)
    );

    btn_sync u_sync_hour (
        .clk_i  (CP_100MHz),
        .rst_ni (nCLR),
        .d_i    (Adj_Hour),
        .q_o    (hour_s)
    );

    // Once a press is claimed only the owning button is watched.
    assign owner_lvl = (owner_q == SEL_HOUR) ? hour_s : min_s;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        adj_sel_d = adj_sel_q;
        step      = 1'b0;
        case (state_q)
            IDLE: begin
                if (min_s || hour_s) begin
                    state_d = DEBOUNCE;
                    cnt_d   = DB_LOAD;
                    owner_d = min_s ? SEL_MIN : SEL_HOUR;
                end
            end
            DEBOUNCE: begin
                if (!owner_lvl) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d   = HELD;
                    step      = 1'b1;
                    adj_sel_d = owner_q;
                    cnt_d     = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HELD: begin
                if (!owner_lvl) begin
                    state_d = RELEASE;
                    cnt_d   = DB_LOAD;
`ifdef AUTO_REPEAT_EN
                end else if (cnt_q == '0) begin
                    state_d = REPEAT;
                    step    = 1'b1;
                    cnt_d   = RATE_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
`endif
                end
            end
`ifdef AUTO_REPEAT_EN
            REPEAT: begin
                if (!owner_lvl) begin
                    state_d = RELEASE;
                    cnt_d   = DB_LOAD;
                end else if (cnt_q == '0) begin
                    step  = 1'b1;
                    cnt_d = RATE_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            RELEASE: begin
                if (owner_lvl) begin
                    state_d = HELD;
                    cnt_d   = HOLD_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so ticks and steps never share a cycle.
    assign min_inc_d    = step && (owner_q == SEL_MIN);
    assign hour_inc_d   = step && (owner_q == SEL_HOUR);
    assign adj_active_d = (state_d == HELD) || (state_d == REPEAT) || (state_d == RELEASE);
    assign sec_inc_d    = tick_1hz && EN && ((state_d == IDLE) || (state_d == DEBOUNCE));

    always_ff @(posedge CP_100MHz) begin
        if (!nCLR) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            owner_q      <= SEL_MIN;
            adj_sel_q    <= SEL_MIN;
            min_inc_q    <= 1'b0;
            hour_inc_q   <= 1'b0;
            sec_inc_q    <= 1'b0;
            adj_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            adj_sel_q    <= adj_sel_d;
            min_inc_q    <= min_inc_d;
            hour_inc_q   <= hour_inc_d;
            sec_inc_q    <= sec_inc_d;
            adj_active_q <= adj_active_d;
        end
    end

    assign sec_inc    = sec_inc_q;
    assign min_inc    = min_inc_q;
    assign hour_inc   = hour_inc_q;
    assign adj_active = adj_active_q;
    assign adj_sel    = adj_sel_q;

endmodule

// File: tb/tb_clock_adjust_ctrl.sv
// Directed bench for clock_adjust_ctrl with a strobe scoreboard (DB=4, HOLD=10, RATE=3).
module tb_clock_adjust_ctrl;

    localparam int DB   = 4;
    localparam int HOLD = 10;
    localparam int RATE = 3;

    localparam int K_SEC  = 0;
    localparam int K_MIN  = 1;
    localparam int K_HOUR = 2;

    logic clk = 1'b0;
    logic nCLR, EN, tick_1hz, Adj_Minute, Adj_Hour;
    logic sec_inc, min_inc, hour_inc, adj_active, adj_sel;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;
    exp_t sbq[$];

    clock_adjust_ctrl #(
        .DB_CYCLES   (DB),
        .HOLD_CYCLES (HOLD),
        .RATE_CYCLES (RATE)
    ) dut (
        .CP_100MHz  (clk),
        .nCLR       (nCLR),
        .EN         (EN),
        .tick_1hz   (tick_1hz),
        .Adj_Minute (Adj_Minute),
        .Adj_Hour   (Adj_Hour),
        .sec_inc    (sec_inc),
        .min_inc    (min_inc),
        .hour_inc   (hour_inc),
        .adj_active (adj_active),
        .adj_sel    (adj_sel)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        sbq.push_back(e);
    endtask

    // Expected strobes for one press driven at cycle n and released at cycle n+rel.
    task automatic push_press(input int kind, input int n, input int rel, output int idle);
        int seen_low;
        seen_low = n + rel + 3;
        push(kind, n + 3 + DB);
`ifdef AUTO_REPEAT_EN
        for (int r = n + 3 + DB + HOLD; r < seen_low; r += RATE) push(kind, r);
`endif
        idle = seen_low + DB;
    endtask

    task automatic pop_chk(input int kind);
        exp_t e;
        checks++;
        assert (sbq.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_strobe: observed kind %0d at cyc %0d, expected none", kind, cyc);
        end
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("strobe_kind", kind, e.kind);
            chk("strobe_cycle", cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (sec_inc === 1'b1)  pop_chk(K_SEC);
        if (min_inc === 1'b1)  pop_chk(K_MIN);
        if (hour_inc === 1'b1) pop_chk(K_HOUR);
    end

    task automatic drain(input string tag);
        chk(tag, sbq.size(), 0);
        sbq.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, idle;
        nCLR = 1'b0; EN = 1'b1; tick_1hz = 1'b0; Adj_Minute = 1'b0; Adj_Hour = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sec_inc", sec_inc, 0);
        chk("rst_min_inc", min_inc, 0);
        chk("rst_hour_inc", hour_inc, 0);
        chk("rst_adj_active", adj_active, 0);
        chk("rst_adj_sel", adj_sel, 0);
        @(posedge clk); #1;
        nCLR = 1'b1;

        // Glitch shorter than the debounce window
        n = cyc;
        for (int off = 0; off < 16; off++) begin
            Adj_Minute = (off < 3);
            @(negedge clk);
            if (off == 8 || off == 12) chk("short_adj_active", adj_active, 0);
            @(posedge clk); #1;
        end
        drain("short_drain");

        // Minute held for 40 cycles
        n = cyc;
        push_press(K_MIN, n, 40, idle);
        for (int off = 0; off < 55; off++) begin
            Adj_Minute = (off < 40);
            @(negedge clk);
            if (off == 6)  chk("hold_active_pre", adj_active, 0);
            if (off == 7)  chk("hold_active_rise", adj_active, 1);
            if (off == 8)  chk("hold_sel_min", adj_sel, 0);
            if (off == idle - n - 1) chk("hold_active_last", adj_active, 1);
            if (off == idle - n)     chk("hold_active_fall", adj_active, 0);
            @(posedge clk); #1;
        end
        drain("hold_drain");

        // Both rise together: minute wins, hour follows after minute release
        n = cyc;
        push_press(K_MIN, n, 21, idle);
        push(K_HOUR, n + idle - n + 1 + DB);
        for (int off = 0; off < 55; off++) begin
            Adj_Minute = (off < 21);
            Adj_Hour   = (off < 38);
            @(negedge clk);
            if (off == 7)  chk("both_sel_min", adj_sel, 0);
            if (off == 30) chk("both_gap_active", adj_active, 0);
            if (off == 34) chk("both_sel_hour", adj_sel, 1);
            if (off == 45) chk("both_active_fall", adj_active, 0);
            if (off == 50) chk("both_sel_holds", adj_sel, 1);
            @(posedge clk); #1;
        end
        drain("both_drain");

        // Ticks while idle with EN=1
        n = cyc;
        push(K_SEC, n + 1);
        push(K_SEC, n + 21);
        push(K_SEC, n + 41);
        for (int off = 0; off < 45; off++) begin
            tick_1hz = (off == 0 || off == 20 || off == 40);
            @(negedge clk);
            @(posedge clk); #1;
        end
        tick_1hz = 1'b0;
        drain("tick_idle_drain");

        // Ticks around a held press: allowed in DEBOUNCE, dropped while adjusting
        n = cyc;
        push(K_SEC, n + 3);
        push_press(K_MIN, n, 30, idle);
        push(K_SEC, n + 43);
        for (int off = 0; off < 50; off++) begin
            Adj_Minute = (off < 30);
            tick_1hz   = (off == 2 || off == 16 || off == 22 || off == 42);
            @(negedge clk);
            if (off == 23) chk("tick_hold_active", adj_active, 1);
            @(posedge clk); #1;
        end
        tick_1hz = 1'b0;
        drain("tick_hold_drain");

        // EN low: no seconds, hour adjust still works
        EN = 1'b0;
        n = cyc;
        push_press(K_HOUR, n, 21, idle);
        for (int off = 0; off < 40; off++) begin
            Adj_Hour = (off < 21);
            tick_1hz = (off == 2 || off == 32);
            @(negedge clk);
            if (off == 8) chk("en0_sel_hour", adj_sel, 1);
            @(posedge clk); #1;
        end
        tick_1hz = 1'b0;
        EN = 1'b1;
        drain("en0_drain");

        // Reset mid-press, then the still-held button debounces afresh
        n = cyc;
        push(K_MIN, n + 7);
`ifdef AUTO_REPEAT_EN
        push(K_MIN, n + 17);
        push(K_MIN, n + 20);
`endif
        push(K_MIN, n + 31);
        for (int off = 0; off < 50; off++) begin
            Adj_Minute = (off < 35);
            nCLR       = !(off >= 21 && off < 24);
            @(negedge clk);
            if (off == 21) chk("rst_mid_active_pre", adj_active, 1);
            if (off == 22) begin
                chk("rst_mid_active", adj_active, 0);
                chk("rst_mid_sel", adj_sel, 0);
                chk("rst_mid_min", min_inc, 0);
                chk("rst_mid_hour", hour_inc, 0);
                chk("rst_mid_sec", sec_inc, 0);
            end
            if (off == 30) chk("rst_post_active_pre", adj_active, 0);
            if (off == 31) chk("rst_post_active", adj_active, 1);
            @(posedge clk); #1;
        end
        drain("rst_mid_drain");

        // Hour held for 100 cycles
        n = cyc;
        push_press(K_HOUR, n, 100, idle);
        for (int off = 0; off < 112; off++) begin
            Adj_Hour = (off < 100);
            @(negedge clk);
            if (off == idle - n) chk("long_active_fall", adj_active, 0);
            @(posedge clk); #1;
        end
        drain("long_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
